// File: rtl/wasm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wasm_mem_pkg
// Purpose  : Shared definitions for the genrom read-port arbiter:
//            - the arbiter state encoding
//            - the data-width helper (2**MEM_EXTRA*8)
//            - well-known requester indices
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wasm_mem_pkg;

  // IDLE: no transaction, WAIT: ROM access in flight, RESP: ack cycle
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;

  // Data width is the burst size in bytes times eight.
  function automatic int data_width(input int mem_extra);
    return (2 ** mem_extra) * 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : wasm_rr_picker
// Purpose  : Combinational rotating-priority picker. The first set request
//            at or above ptr_i wins; if none, the search wraps to index 0.
// Ports    : req_i   [NUM_REQ-1:0]  candidate request vector
//            ptr_i   [PTR_W-1:0]    index with highest priority
//            gnt_o   [NUM_REQ-1:0]  one-hot winner (zero when none)
//            valid_o                a winner exists
// Revision : 1.0 - initial release
// ============================================================================
module wasm_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic w_found;

  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    // First pass: indices at or above the pointer.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
        gnt_o[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    // Second pass: wrap around to the indices below the pointer.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_i[i] && (PTR_W'(i) < ptr_i)) begin
        gnt_o[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    valid_o = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/wasm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wasm_mem_arbiter
// Purpose  : Shares the single genrom read port between NUM_REQ requesters
//            (index 0 = instruction fetch). Each transaction issues the
//            owner's address/extra/window onto mem_*, waits ROM_LATENCY
//            cycles, captures mem_data/mem_error and pulses ack for one
//            cycle. Back-to-back issue straight from the ack cycle.
// Ports    : clk_i, reset_i (async, active-high)
//            req_i / req_addr_i / req_extra_i / req_lower_i / req_upper_i
//            gnt_o, ack_o, rdata_o, rerror_o        requester side
//            mem_addr_o/extra_o/lower_o/upper_o     to genrom
//            mem_data_i, mem_error_i                from genrom
// Config   : WASM_MEM_ARB_FIXED_PRIO_EN - fixed priority (lowest index
//            wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module wasm_mem_arbiter
  import wasm_mem_pkg::*;
#(
  parameter int MEM_ADDR    = 4,
  parameter int MEM_EXTRA   = 4,
  parameter int NUM_REQ     = 2,
  parameter int ROM_LATENCY = 1,
  localparam int DATA_W     = data_width(MEM_EXTRA),
  localparam int AW         = MEM_ADDR + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*AW-1:0]        req_addr_i,
  input  logic [NUM_REQ*MEM_EXTRA-1:0] req_extra_i,
  input  logic [NUM_REQ*AW-1:0]        req_lower_i,
  input  logic [NUM_REQ*AW-1:0]        req_upper_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         rerror_o,
  output logic [AW-1:0]                mem_addr_o,
  output logic [MEM_EXTRA-1:0]         mem_extra_o,
  output logic [AW-1:0]                mem_lower_o,
  output logic [AW-1:0]                mem_upper_o,
  input  logic [DATA_W-1:0]            mem_data_i,
  input  logic                         mem_error_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = 3;

  arb_state_e               state_q, state_d;
  logic [CNT_W-1:0]         lat_cnt_q, lat_cnt_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     rerror_q, rerror_d;
  logic [AW-1:0]            mem_addr_q, mem_addr_d;
  logic [MEM_EXTRA-1:0]     mem_extra_q, mem_extra_d;
  logic [AW-1:0]            mem_lower_q, mem_lower_d;
  logic [AW-1:0]            mem_upper_q, mem_upper_d;
  logic [PTR_W-1:0]         rr_ptr_d;

  logic [NUM_REQ-1:0]       w_pick_req;
  logic [NUM_REQ-1:0]       w_pick_gnt;
  logic                     w_pick_valid;
  logic [PTR_W-1:0]         w_ptr;
  logic                     w_issue;

`ifdef WASM_MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: search always starts at index 0; no pointer state.
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q;

  assign w_ptr = rr_ptr_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // In RESP the owner still holds req during its ack cycle, so it is
  // masked out of the back-to-back decision.
  assign w_pick_req = (state_q == ARB_RESP) ? (req_i & ~gnt_q) : req_i;

  wasm_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (w_pick_req),
    .ptr_i   (w_ptr),
    .gnt_o   (w_pick_gnt),
    .valid_o (w_pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    rerror_d    = rerror_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;
    mem_lower_d = mem_lower_q;
    mem_upper_d = mem_upper_q;
    rr_ptr_d    = w_ptr;
    w_issue     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        w_issue = w_pick_valid;
      end
      ARB_WAIT: begin
        if (lat_cnt_q == CNT_W'(ROM_LATENCY - 1)) begin
          rdata_d   = mem_data_i;
          rerror_d  = mem_error_i;
          lat_cnt_d = '0;
          state_d   = ARB_RESP;
          // An owner that withdrew its request gets no ack; the ROM
          // result is still captured.
          ack_d     = gnt_q & req_i;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        gnt_d = '0;
        if (w_pick_valid) w_issue = 1'b1;
        else              state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (w_issue) begin
      state_d   = ARB_WAIT;
      lat_cnt_d = '0;
      gnt_d     = w_pick_gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_pick_gnt[i]) begin
          mem_addr_d  = req_addr_i[i*AW +: AW];
          mem_extra_d = req_extra_i[i*MEM_EXTRA +: MEM_EXTRA];
          mem_lower_d = req_lower_i[i*AW +: AW];
          mem_upper_d = req_upper_i[i*AW +: AW];
          rr_ptr_d    = PTR_W'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ARB_IDLE;
      lat_cnt_q   <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      rerror_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      mem_lower_q <= '0;
      mem_upper_q <= '1;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rerror_q    <= rerror_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
      mem_lower_q <= mem_lower_d;
      mem_upper_q <= mem_upper_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign rerror_o    = rerror_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_extra_o = mem_extra_q;
  assign mem_lower_o = mem_lower_q;
  assign mem_upper_o = mem_upper_q;

endmodule
`default_nettype wire

// File: tb/tb_wasm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wasm_mem_arbiter
// Purpose  : Directed self-checking bench for wasm_mem_arbiter with default
//            parameters (MEM_ADDR=4, MEM_EXTRA=4, NUM_REQ=2, ROM_LATENCY=1).
//            The ROM stand-in is combinational: byte 0 = addr ^ 0x2F,
//            error when addr lies outside [lower, upper].
// Revision : 1.0 - initial release
// ============================================================================
module tb_wasm_mem_arbiter;

  localparam int AW = 5;
  localparam int EW = 4;
  localparam int NR = 2;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*EW-1:0]  req_extra;
  logic [NR*AW-1:0]  req_lower;
  logic [NR*AW-1:0]  req_upper;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              rerror;
  logic [AW-1:0]     mem_addr;
  logic [EW-1:0]     mem_extra;
  logic [AW-1:0]     mem_lower;
  logic [AW-1:0]     mem_upper;
  logic [DW-1:0]     mem_data;
  logic              mem_error;

  int n_assert = 0;
  int n_fail   = 0;

  wasm_mem_arbiter dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .req_addr_i  (req_addr),
    .req_extra_i (req_extra),
    .req_lower_i (req_lower),
    .req_upper_i (req_upper),
    .gnt_o       (gnt),
    .ack_o       (ack),
    .rdata_o     (rdata),
    .rerror_o    (rerror),
    .mem_addr_o  (mem_addr),
    .mem_extra_o (mem_extra),
    .mem_lower_o (mem_lower),
    .mem_upper_o (mem_upper),
    .mem_data_i  (mem_data),
    .mem_error_i (mem_error)
  );

  always #5 clk = ~clk;

  assign mem_data  = {{(DW-8){1'b0}}, ({3'b000, mem_addr} ^ 8'h2F)};
  assign mem_error = (mem_addr < mem_lower) || (mem_addr > mem_upper);

  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] addr,
                         input logic [AW-1:0] lower, input logic [AW-1:0] upper);
    req_addr[idx*AW +: AW]  = addr;
    req_extra[idx*EW +: EW] = '0;
    req_lower[idx*AW +: AW] = lower;
    req_upper[idx*AW +: AW] = upper;
    req[idx]                = 1'b1;
  endtask

  function automatic logic [DW-1:0] byte0(input logic [7:0] b);
    return {{(DW-8){1'b0}}, b};
  endfunction

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_extra = '0;
    req_lower = '0; req_upper = '0;
    tick(); tick();

    // Reset state
    check_val("rst_gnt",   gnt,       '0);
    check_val("rst_ack",   ack,       '0);
    check_val("rst_rdata", rdata,     '0);
    check_val("rst_addr",  mem_addr,  '0);
    check_val("rst_lower", mem_lower, '0);
    check_val("rst_upper", mem_upper, 5'h1F);

    // Single fetch at address 5
    reset = 1'b0;
    set_req(0, 5'd5, 5'd0, 5'd31);
    tick();
    check_val("s1_gnt",    gnt,      2'b01);
    check_val("s1_addr",   mem_addr, 5'd5);
    check_val("s1_noack",  ack,      2'b00);
    tick();
    check_val("s1_ack",    ack,      2'b01);
    check_val("s1_rdata",  rdata,    byte0(8'h2A));
    check_val("s1_rerr",   rerror,   1'b0);
    req[0] = 1'b0;
    tick();
    check_val("s1_idle_gnt",  gnt,      2'b00);
    check_val("s1_idle_ack",  ack,      2'b00);
    check_val("s1_hold_addr", mem_addr, 5'd5);

    // Both requests held from reset release: 0 first, then 1 back-to-back
    reset = 1'b1; tick();
    set_req(0, 5'd3, 5'd0, 5'd31);
    set_req(1, 5'd7, 5'd0, 5'd31);
    reset = 1'b0;
    tick();
    check_val("s2_gnt0",  gnt,      2'b01);
    check_val("s2_addr0", mem_addr, 5'd3);
    tick();
    check_val("s2_ack0",  ack,      2'b01);
    check_val("s2_data0", rdata,    byte0(8'h2C));
    req[0] = 1'b0;
    tick();
    check_val("s2_gnt1",  gnt,      2'b10);
    check_val("s2_addr1", mem_addr, 5'd7);
    check_val("s2_gap",   ack,      2'b00);
    tick();
    check_val("s2_ack1",  ack,      2'b10);
    check_val("s2_data1", rdata,    byte0(8'h28));
    req[1] = 1'b0;
    tick();
    check_val("s2_idle",  gnt,      2'b00);
    // Pointer wrapped to 0: a fresh simultaneous request goes to 0
    req = 2'b11;
    tick();
    check_val("s2_wrap_gnt", gnt, 2'b01);
    tick();
    check_val("s2_wrap_ack", ack, 2'b01);
    req = 2'b00;
    tick();
    check_val("s2_wrap_idle", gnt, 2'b00);

    // Out-of-window access on requester 1
    set_req(1, 5'd8, 5'd0, 5'd3);
    tick();
    check_val("s3_gnt",   gnt,       2'b10);
    check_val("s3_lower", mem_lower, 5'd0);
    check_val("s3_upper", mem_upper, 5'd3);
    tick();
    check_val("s3_ack",   ack,       2'b10);
    check_val("s3_rerr",  rerror,    1'b1);
    req[1] = 1'b0;
    tick();

    // Reset during WAIT aborts the transaction
    set_req(0, 5'd9, 5'd0, 5'd31);
    tick();
    check_val("s4_gnt", gnt, 2'b01);
    reset = 1'b1;
    #1;
    check_val("s4_rst_gnt",   gnt,       '0);
    check_val("s4_rst_addr",  mem_addr,  '0);
    check_val("s4_rst_upper", mem_upper, 5'h1F);
    check_val("s4_rst_rdata", rdata,     '0);
    check_val("s4_rst_rerr",  rerror,    1'b0);
    tick();
    check_val("s4_rst_ack",   ack,       '0);
    reset = 1'b0;
    tick();
    check_val("s4_re_gnt",  gnt,      2'b01);
    check_val("s4_re_addr", mem_addr, 5'd9);
    tick();
    check_val("s4_re_ack",  ack,      2'b01);
    check_val("s4_re_data", rdata,    byte0(8'h26));
    req[0] = 1'b0;
    tick();

    // Requester 1 withdraws during WAIT: no ack, data still captured
    set_req(1, 5'd2, 5'd0, 5'd31);
    tick();
    check_val("s5_gnt", gnt, 2'b10);
    req[1] = 1'b0;
    tick();
    check_val("s5_noack", ack,   2'b00);
    check_val("s5_data",  rdata, byte0(8'h2D));
    tick();
    check_val("s5_idle",  gnt,   2'b00);
    check_val("s5_idle_ack", ack, 2'b00);
    set_req(0, 5'd4, 5'd0, 5'd31);
    tick();
    check_val("s5_gnt0", gnt, 2'b01);
    tick();
    check_val("s5_ack0",  ack,   2'b01);
    check_val("s5_data0", rdata, byte0(8'h2B));
    req[0] = 1'b0;
    tick();

    // Last grant went to 0, so 1 now has priority
    set_req(0, 5'd1, 5'd0, 5'd31);
    set_req(1, 5'd6, 5'd0, 5'd31);
    tick();
    check_val("s6_gnt1", gnt, 2'b10);
    tick();
    check_val("s6_ack1",  ack,   2'b10);
    check_val("s6_data1", rdata, byte0(8'h29));
    req[1] = 1'b0;
    tick();
    check_val("s6_gnt0", gnt, 2'b01);
    tick();
    check_val("s6_ack0",  ack,   2'b01);
    check_val("s6_data0", rdata, byte0(8'h2E));
    req[0] = 1'b0;
    tick();
    check_val("s6_idle", gnt, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
